// File: rtl/pong_button_conditioner_pkg.sv
// Shared constants for the Pong push-button conditioner: board sizing, in_port
// field layout and button indices.
package pong_button_conditioner_pkg;

    localparam int PONG_NUM_BTN         = 4;
    localparam int PONG_DEBOUNCE_CYCLES = 500000;

    // in_port = {press_toggle, level}; toggle field sits directly above level.
    localparam int LEVEL_LSB  = 0;
    localparam int TOGGLE_LSB = PONG_NUM_BTN;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_SERVE = 2;
    localparam int BTN_PAUSE = 3;

    // Raw pin value of a released button.
    function automatic logic idle_raw(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/pong_debounce_chan.sv
// One button channel: 2-FF synchronizer, polarity normalization, counter debounce,
// debounced level plus press toggle and single-cycle press strobe.
module pong_debounce_chan
    import pong_button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = PONG_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic level_o,
    output logic toggle_o,
    output logic pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic RAW_IDLE = idle_raw(ACTIVE_LOW);

    logic             sync1_q, sync2_q;
    logic             norm;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             toggle_q, toggle_d;
    logic             pulse_q, pulse_d;

    assign norm = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        cnt_d    = '0;
        level_d  = level_q;
        toggle_d = toggle_q;
        pulse_d  = 1'b0;
        if (norm != level_q) begin
            if (cnt_q == CNT_LAST) begin
                // Level has disagreed for the full window: accept it.
                level_d = norm;
                if (norm) begin
                    toggle_d = ~toggle_q;
                    pulse_d  = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= RAW_IDLE;
            sync2_q  <= RAW_IDLE;
            cnt_q    <= '0;
            level_q  <= 1'b0;
            toggle_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            toggle_q <= toggle_d;
            pulse_q  <= pulse_d;
        end
    end

    assign level_o  = level_q;
    assign toggle_o = toggle_q;
    assign pulse_o  = pulse_q;

endmodule

// File: rtl/pong_button_conditioner.sv
// Pong board button conditioner: one debounce channel per button, packed into the
// read-only PIO word {press_toggle, level} plus a press strobe for hardware users.
module pong_button_conditioner
    import pong_button_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = PONG_NUM_BTN,
    parameter int DEBOUNCE_CYCLES = PONG_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_BTN-1:0]   raw_btn,
    output logic [2*NUM_BTN-1:0] in_port,
    output logic [NUM_BTN-1:0]   press_pulse
);

    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] toggle;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        pong_debounce_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .raw_i    (raw_btn[g]),
            .level_o  (level[g]),
            .toggle_o (toggle[g]),
            .pulse_o  (press_pulse[g])
        );
    end

    // Toggle field follows the level field, whatever the button count.
    assign in_port[LEVEL_LSB +: NUM_BTN]           = level;
    assign in_port[LEVEL_LSB + NUM_BTN +: NUM_BTN] = toggle;

endmodule
